// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the 6502 firmware boot loader.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_VEC_LO,
    LDR_VEC_HI,
    LDR_HOLD,
    LDR_DONE
  } ldr_state_t;

  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
  localparam int          ADDR_WIDTH   = 16;
  localparam int          REG_WIDTH    = 8;

endpackage

// File: rtl/mem_loader_reset_stretch.sv
// Down-counter that keeps the CPU in reset for HOLD_CYCLES cycles once HOLD is entered.
module reset_stretch #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int               CNT_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Held at the reload value outside HOLD, so the first HOLD cycle already counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_loader.sv
// Streams a firmware image into system memory, patches the reset vector and
// releases the CPU from reset after a hold interval.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = mem_loader_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = REG_WIDTH,
  parameter int                    LEN_WIDTH    = 17,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR  = ADDR_WIDTH'(RESET_VECTOR),
  parameter bit                    WRITE_VECTOR = 1'b1,
  parameter int                    HOLD_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  localparam logic [SUM_W-1:0] MEM_SIZE = SUM_W'(1) << ADDR_WIDTH;

  ldr_state_t              state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    count;
  logic [SUM_W-1:0]        end_addr;
  logic                    overflow;
  logic [15:0]             base16;
  logic                    hold_expired;

  // An image ending exactly at the top of memory is legal; anything past it would wrap.
  assign end_addr = SUM_W'(base_addr) + SUM_W'(length);
  assign overflow = (end_addr > MEM_SIZE);
  assign base16   = 16'(base_q);

  reset_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_reset_stretch (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (state != LDR_HOLD),
    .expired(hold_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LDR_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count       <= '0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LDR_IDLE, LDR_DONE: begin
          if (start) begin
            if (overflow) begin
              error <= 1'b1;
            end else begin
              error       <= 1'b0;
              base_q      <= base_addr;
              len_q       <= length;
              count       <= '0;
              cpu_reset_n <= 1'b0;
              busy        <= 1'b1;
              done        <= 1'b0;
              if (length != '0) begin
                state    <= LDR_LOAD;
                in_ready <= 1'b1;
              end else if (WRITE_VECTOR) begin
                state <= LDR_VEC_LO;
              end else begin
                state <= LDR_HOLD;
              end
            end
          end
        end

        LDR_LOAD: begin
          if (in_valid && in_ready) begin
            mem_we   <= 1'b1;
            mem_addr <= base_q + ADDR_WIDTH'(count);
            mem_din  <= in_data;
            count    <= count + 1'b1;
            if (count == len_q - 1'b1) begin
              in_ready <= 1'b0;
              state    <= WRITE_VECTOR ? LDR_VEC_LO : LDR_HOLD;
            end
          end
        end

        // Vector halves are always bytes of the base, zero-padded above ADDR_WIDTH.
        LDR_VEC_LO: begin
          mem_we   <= 1'b1;
          mem_addr <= VECTOR_ADDR;
          mem_din  <= DATA_WIDTH'(base16[7:0]);
          state    <= LDR_VEC_HI;
        end

        LDR_VEC_HI: begin
          mem_we   <= 1'b1;
          mem_addr <= VECTOR_ADDR + 1'b1;
          mem_din  <= DATA_WIDTH'(base16[15:8]);
          state    <= LDR_HOLD;
        end

        LDR_HOLD: begin
          if (hold_expired) begin
            state       <= LDR_DONE;
            cpu_reset_n <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end

        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed loads, expected writes queued, checked by a write monitor.
module tb_mem_loader;

  localparam int HOLD = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;

  int          n_cmp;
  int          n_bad;
  logic [23:0] sb_q[$];
  logic [23:0] sb_exp;
  logic [7:0]  mem_img [0:65535];
  logic [7:0]  pat [8];
  int          rel_cnt;

  mem_loader #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Memory-side monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      mem_img[mem_addr] = mem_din;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_din);
      end else begin
        sb_exp = sb_q.pop_front();
        check("mem_write", {8'h00, mem_addr, mem_din}, {8'h00, sb_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic start_load(input logic [15:0] b, input logic [16:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_release(output int cnt);
    cnt = 0;
    while (!cpu_reset_n && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic set_pat(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pat[0] = b0;
    pat[1] = b1;
    pat[2] = b2;
  endtask

  // Full load of n bytes from pat[] with optional idle cycles between bytes.
  task automatic run_load(input logic [15:0] b, input int n, input int gap, input string tag);
    for (int i = 0; i < n; i++) push(b + 16'(i), pat[i]);
    push(16'hFFFC, b[7:0]);
    push(16'hFFFD, b[15:8]);
    start_load(b, 17'(n));
    check({tag, "_error_clear"}, {31'd0, error}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_cpu_held"}, {31'd0, cpu_reset_n}, 32'd0);
    check({tag, "_ready_first"}, {31'd0, in_ready}, (n > 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < n; i++) send(pat[i], (i == 0) ? 0 : gap);
    if (n > 0) check({tag, "_ready_after_last"}, {31'd0, in_ready}, 32'd0);
    wait_release(rel_cnt);
    check({tag, "_release_edges"}, 32'(rel_cnt), 32'(2 + HOLD));
    check({tag, "_done"}, {30'd0, done, busy}, 32'd2);
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    for (int a = 0; a < 65536; a++) mem_img[a] = 8'h00;
    for (int i = 0; i < 8; i++) pat[i] = 8'h00;

    repeat (3) tick();
    check("rst_flags", {26'd0, cpu_reset_n, in_ready, mem_we, busy, done, error}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_din", {24'd0, mem_din}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Back-to-back stream.
    set_pat(8'hA9, 8'h01, 8'h00);
    run_load(16'h0200, 3, 0, "cont");
    check("cont_img0", {24'd0, mem_img[16'h0200]}, 32'hA9);
    check("cont_img1", {24'd0, mem_img[16'h0201]}, 32'h01);
    check("cont_vec", {16'd0, mem_img[16'hFFFD], mem_img[16'hFFFC]}, 32'h0200);

    // Same image with in_valid toggling.
    mem_img[16'h0200] = 8'h55;
    mem_img[16'h0201] = 8'h55;
    mem_img[16'h0202] = 8'h55;
    run_load(16'h0200, 3, 1, "togl");
    check("togl_img", {8'd0, mem_img[16'h0200], mem_img[16'h0201], mem_img[16'h0202]}, 32'h00A90100);

    // Over-range request from DONE is rejected without side effects.
    start_load(16'hFFFE, 17'd4);
    check("rej_error", {31'd0, error}, 32'd1);
    check("rej_state", {29'd0, done, busy, in_ready}, 32'd4);
    check("rej_cpu", {31'd0, cpu_reset_n}, 32'd1);
    repeat (3) tick();
    check("rej_error_sticky", {31'd0, error}, 32'd1);

    // Zero-length load: vector writes only.
    run_load(16'h8000, 0, 0, "zero");
    check("zero_vec", {16'd0, mem_img[16'hFFFD], mem_img[16'hFFFC]}, 32'h8000);

    // Image ending exactly at the top of memory is accepted.
    set_pat(8'h77, 8'h00, 8'h00);
    run_load(16'hFFFF, 1, 0, "top");
    check("top_img", {24'd0, mem_img[16'hFFFF]}, 32'h77);

    // Image covering the vector: patch wins.
    set_pat(8'h11, 8'h22, 8'h00);
    run_load(16'hFFFC, 2, 0, "ovl");
    check("ovl_vec", {16'd0, mem_img[16'hFFFD], mem_img[16'hFFFC]}, 32'hFFFC);

    // Asynchronous reset in the middle of a 5-byte load.
    push(16'h0300, 8'h31);
    push(16'h0301, 8'h32);
    start_load(16'h0300, 17'd5);
    send(8'h31, 0);
    send(8'h32, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    check("abort_we_before", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_cpu", {30'd0, cpu_reset_n, busy}, 32'd0);
    in_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("abort_img", {8'd0, mem_img[16'h0300], mem_img[16'h0301], mem_img[16'h0302]}, 32'h00313200);
    check("abort_sb", 32'(sb_q.size()), 32'd0);
    set_pat(8'h41, 8'h42, 8'h00);
    run_load(16'h0400, 2, 0, "post");
    check("post_img", {16'd0, mem_img[16'h0400], mem_img[16'h0401]}, 32'h4142);

    // start during LOAD is ignored.
    push(16'h0500, 8'h51);
    push(16'h0501, 8'h52);
    push(16'h0502, 8'h53);
    push(16'hFFFC, 8'h00);
    push(16'hFFFD, 8'h05);
    start_load(16'h0500, 17'd3);
    send(8'h51, 0);
    start_load(16'h0600, 17'd1);
    check("ign_busy", {30'd0, busy, in_ready}, 32'd3);
    send(8'h52, 0);
    send(8'h53, 0);
    check("ign_ready_after_last", {31'd0, in_ready}, 32'd0);
    wait_release(rel_cnt);
    check("ign_release_edges", 32'(rel_cnt), 32'(2 + HOLD));
    check("ign_img", {8'd0, mem_img[16'h0500], mem_img[16'h0501], mem_img[16'h0502]}, 32'h00515253);
    check("ign_sb_drained", 32'(sb_q.size()), 32'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Parametrised boot loader for the 6502 system memory. It streams firmware bytes through a valid/ready port into system memory starting at a programmable base address, then patches the reset vector to point at that base. It holds the CPU in reset throughout the load and releases it after a programmable hold interval. It sits between the testbench or host stream source and the `mem` write port, and drives the `reset_n` input of `cpu_top`.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 8: memory data width; the vector write always uses 8-bit halves.
- `LEN_WIDTH`, default 17: width of `length`, enough for a full 64 KiB image.
- `VECTOR_ADDR`, default 16'hFFFC: address of the low byte of the reset vector.
- `WRITE_VECTOR`, default 1: 1 patches the vector after the load; 0 skips the patch.
- `HOLD_CYCLES`, default 4: cycles `cpu_reset_n` stays low after the last write; minimum 1.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle load request; sampled only in IDLE or DONE.
- `base_addr` in ADDR_WIDTH: first write address; sampled with `start`.
- `length` in LEN_WIDTH: byte count; sampled with `start`.
- `in_valid` in 1: stream byte valid.
- `in_data` in DATA_WIDTH: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: registered memory write strobe.
- `mem_addr` out ADDR_WIDTH: registered write address.
- `mem_din` out DATA_WIDTH: registered write data.
- `cpu_reset_n` out 1: drives `cpu_top.reset_n`.
- `busy` out 1: high in LOAD, VEC_LO, VEC_HI and HOLD.
- `done` out 1: level; high in DONE.
- `error` out 1: sticky; high when the last `start` was rejected.

## Operation
- States: IDLE → LOAD → VEC_LO → VEC_HI → HOLD → DONE. VEC_LO and VEC_HI are skipped when `WRITE_VECTOR`=0.
- **IDLE/DONE, `start`=1:**
  - Latch `base_addr` and `length`.
  - Clear `error`.
  - Drive `cpu_reset_n` low.
  - Go to LOAD. If `length`=0, go directly to VEC_LO, or to HOLD when `WRITE_VECTOR`=0.
- **Rejection:** if `base_addr + length > 2**ADDR_WIDTH`, do not wrap. Set `error`, stay in the current state, and leave `cpu_reset_n` unchanged.
- **Overlap:** if the image covers VECTOR_ADDR or VECTOR_ADDR+1 and `WRITE_VECTOR`=1, the vector patch overwrites those image bytes.
- **LOAD:**
  - `in_ready`=1.
  - Each handshake (`in_valid && in_ready`) registers one write: `mem_addr` = base + count, `mem_din` = `in_data`, `mem_we`=1 for one cycle.
  - Count increments per handshake. After the handshake that makes count = `length`, go to VEC_LO.
- **VEC_LO:** write `base[7:0]` to VECTOR_ADDR.
- **VEC_HI:** write `base[15:8]` to VECTOR_ADDR+1. Bits above ADDR_WIDTH are zero-padded.
- **HOLD:** count down HOLD_CYCLES cycles, then go to DONE.
- **DONE:** `cpu_reset_n`=1. A new `start` re-enters the sequence and drops `cpu_reset_n` again.
- **Input ignored:** `start` is ignored while `busy`=1.

## Timing
- Reset values:
  - state IDLE.
  - `cpu_reset_n`=0, so the CPU stays in reset until the first completed load.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `busy`=0, `done`=0, `error`=0.
- Write latency: a handshake in cycle N gives `mem_we`/`mem_addr`/`mem_din` valid in cycle N+1.
- Throughput: one byte per cycle; `in_ready` stays high through LOAD.
- `in_ready` is low in the cycle after the final handshake.
- Last-byte sequence, `WRITE_VECTOR`=1: last handshake at N → last data write at N+1 → VEC_LO write at N+2 → VEC_HI write at N+3 → `cpu_reset_n` rises at N+3+HOLD_CYCLES.
- `start` → first `in_ready`=1: next cycle.
- Reset mid-operation: asynchronous reset aborts immediately to reset values, `mem_we` drops the same instant, and the partial image is left in memory.
- `in_valid` may toggle freely; stalls do not advance the count.

## Structure
- Add to `PKG/pkg.v`:
  - `typedef enum {LDR_IDLE, LDR_LOAD, LDR_VEC_LO, LDR_VEC_HI, LDR_HOLD, LDR_DONE}`.
  - `RESET_VECTOR` = 16'hFFFC.
  - Default widths come from `ADDR_WIDTH` / `REG_WIDTH`.
- One sub-module: `reset_stretch`, a HOLD_CYCLES down-counter with `load`/`expired` that produces the `cpu_reset_n` release.

## Test plan
- base=16'h0200, length=3, bytes A9,01,00, `in_valid` held high → writes to 0200..0202 on consecutive cycles; FFFC=00, FFFD=02; `cpu_reset_n` rises 3+HOLD_CYCLES cycles after the last handshake; `done`=1.
- Same load with `in_valid` toggled every other cycle → identical memory contents; the count advances only on handshakes.
- base=16'hFFFE, length=4 → `error`=1, no `mem_we`, state unchanged; then a legal `start` clears `error`.
- length=0, base=16'h8000 → only the vector writes occur (FFFC=00, FFFD=80), then HOLD.
- Assert `reset_n` after 2 of 5 bytes → `mem_we`=0 and `cpu_reset_n`=0 immediately; bytes at base and base+1 persist; after reset release a new `start` completes normally.
- `start` pulsed during LOAD → ignored; latched length/base unchanged.
